// File: rtl/bpsk_tx_framer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bpsk_tx_framer: FIFO-buffered frame builder feeding bpsk_top.data            |
// | Rev 1.0  initial release                                                   |
// +----------------------------------------------------------------------------+
module bpsk_tx_framer #(
  parameter int                    DATA_WIDTH    = 12,
  parameter int                    WORD_PERIOD   = 3072,
  parameter int                    FIFO_DEPTH    = 8,
  parameter int                    PREAMBLE_LEN  = 4,
  parameter logic [DATA_WIDTH-1:0] PREAMBLE_WORD = 12'hA5A,
  parameter int                    GAP_LEN       = 2,
  parameter logic [DATA_WIDTH-1:0] IDLE_WORD     = '0
) (
  input  logic                  clk,
  input  logic                  arstn,
  input  logic                  en,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  underrun
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(WORD_PERIOD);
  localparam int PW = $clog2(PREAMBLE_LEN + 1);
  localparam int GW = (GAP_LEN > 0) ? $clog2(GAP_LEN + 1) : 1;

  localparam logic [TW-1:0] WCNT_MAX  = TW'(WORD_PERIOD - 1);
  localparam logic [PW-1:0] PCNT_END  = PW'(PREAMBLE_LEN);
  localparam logic [GW-1:0] GCNT_END  = GW'(GAP_LEN);
  localparam logic [AW:0]   FIFO_FULL = (AW + 1)'(FIFO_DEPTH);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_PREAMBLE = 2'd1;
  localparam logic [1:0] ST_PAYLOAD  = 2'd2;
  localparam logic [1:0] ST_GAP      = 2'd3;

  // Each FIFO entry keeps the frame-end marker alongside its data.
  logic [DATA_WIDTH:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]         wptr, rptr;
  logic [AW:0]           count, count_nxt;
  logic                  push, pop, empty;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  head_last;

  logic [TW-1:0]         wcnt;
  logic                  wb;
  logic [1:0]            state, state_nxt;
  logic [PW-1:0]         pcnt, pcnt_nxt;
  logic [GW-1:0]         gcnt, gcnt_nxt;
  logic                  last_seen, last_seen_nxt;
  logic [DATA_WIDTH-1:0] data_nxt;
  logic                  frame_done_nxt, underrun_nxt;
  logic                  present, go_idle;

  assign push      = s_valid && s_ready;
  assign empty     = (count == '0);
  assign head_data = mem[rptr][DATA_WIDTH-1:0];
  assign head_last = mem[rptr][DATA_WIDTH];
  assign wb        = en && (wcnt == WCNT_MAX);
  assign busy      = (state != ST_IDLE);

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_comb begin
    state_nxt      = state;
    pcnt_nxt       = pcnt;
    gcnt_nxt       = gcnt;
    last_seen_nxt  = last_seen;
    data_nxt       = data_out;
    frame_done_nxt = 1'b0;
    underrun_nxt   = 1'b0;
    pop            = 1'b0;
    present        = 1'b0;
    go_idle        = 1'b0;
    if (wb) begin
      case (state)
        ST_IDLE: go_idle = 1'b1;
        ST_PREAMBLE: begin
          if (pcnt != PCNT_END) begin
            pcnt_nxt = pcnt + PW'(1);
            data_nxt = PREAMBLE_WORD;
          end else begin
            state_nxt = ST_PAYLOAD;
            present   = 1'b1;
          end
        end
        ST_PAYLOAD: begin
          if (last_seen) begin
            last_seen_nxt = 1'b0;
            if (GAP_LEN > 0) begin
              state_nxt = ST_GAP;
              data_nxt  = IDLE_WORD;
              gcnt_nxt  = GW'(1);
            end else begin
              frame_done_nxt = 1'b1;
              go_idle        = 1'b1;
            end
          end else begin
            present = 1'b1;
          end
        end
        default: begin
          if (gcnt != GCNT_END) begin
            gcnt_nxt = gcnt + GW'(1);
            data_nxt = IDLE_WORD;
          end else begin
            frame_done_nxt = 1'b1;
            go_idle        = 1'b1;
          end
        end
      endcase

      // Frame end re-evaluates the idle rule so queued frames follow back-to-back.
      if (go_idle) begin
        if (!empty) begin
          state_nxt = ST_PREAMBLE;
          data_nxt  = PREAMBLE_WORD;
          pcnt_nxt  = PW'(1);
        end else begin
          state_nxt = ST_IDLE;
          data_nxt  = IDLE_WORD;
        end
      end

      if (present) begin
        if (!empty) begin
          pop           = 1'b1;
          data_nxt      = head_data;
          last_seen_nxt = head_last;
        end else begin
          data_nxt     = IDLE_WORD;
          underrun_nxt = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= {s_last, s_data};
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      s_ready    <= 1'b1;
      wcnt       <= '0;
      state      <= ST_IDLE;
      pcnt       <= '0;
      gcnt       <= '0;
      last_seen  <= 1'b0;
      data_out   <= IDLE_WORD;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      if (push) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      count   <= count_nxt;
      // Registered ready: a pop from a full FIFO reopens the port one cycle later.
      s_ready <= (count_nxt != FIFO_FULL);
      if (en) begin
        wcnt <= wb ? '0 : wcnt + 1'b1;
      end
      state      <= state_nxt;
      pcnt       <= pcnt_nxt;
      gcnt       <= gcnt_nxt;
      last_seen  <= last_seen_nxt;
      data_out   <= data_nxt;
      frame_done <= frame_done_nxt;
      underrun   <= underrun_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bpsk_tx_framer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_bpsk_tx_framer: scoreboard bench for bpsk_tx_framer (GAP_LEN 1 and 0)     |
// | Rev 1.0  initial release                                                   |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_bpsk_tx_framer;

  localparam int WP = 4;

  typedef struct {
    logic [11:0] data;
    logic        fd;
    logic        un;
    logic        busy;
  } exp_t;

  typedef struct {
    logic [11:0] data;
    logic        last;
  } vin_t;

  logic        clk = 1'b0;
  logic        arstn = 1'b0;
  logic        en = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic [11:0] s_data = '0;

  logic        s_ready1, busy1, fd1, un1;
  logic [11:0] data1;
  logic        s_ready2, busy2, fd2, un2;
  logic [11:0] data2;

  bit          sel = 1'b0;
  bit          en_tog = 1'b0;
  int          checks = 0;
  int          errors = 0;
  int          nb = 0;
  int          tcnt;
  logic        pend;
  exp_t        sbq[$];
  exp_t        me;

  bpsk_tx_framer #(
    .DATA_WIDTH(12), .WORD_PERIOD(WP), .FIFO_DEPTH(8), .PREAMBLE_LEN(2),
    .PREAMBLE_WORD(12'hA5A), .GAP_LEN(1), .IDLE_WORD(12'h000)
  ) u_dut1 (
    .clk(clk), .arstn(arstn), .en(en), .s_valid(s_valid), .s_ready(s_ready1),
    .s_data(s_data), .s_last(s_last), .data_out(data1), .busy(busy1),
    .frame_done(fd1), .underrun(un1)
  );

  bpsk_tx_framer #(
    .DATA_WIDTH(12), .WORD_PERIOD(WP), .FIFO_DEPTH(8), .PREAMBLE_LEN(2),
    .PREAMBLE_WORD(12'hA5A), .GAP_LEN(0), .IDLE_WORD(12'h000)
  ) u_dut2 (
    .clk(clk), .arstn(arstn), .en(en), .s_valid(s_valid), .s_ready(s_ready2),
    .s_data(s_data), .s_last(s_last), .data_out(data2), .busy(busy2),
    .frame_done(fd2), .underrun(un2)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (en_tog) en = ~en;
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [11:0] d, input logic f, input logic u, input logic b);
    exp_t e;
    e.data = d; e.fd = f; e.un = u; e.busy = b;
    return e;
  endfunction

  // Reference word timer: flags the cycle right after each en-qualified period end.
  always @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      tcnt <= 0;
      pend <= 1'b0;
    end else begin
      pend <= 1'b0;
      if (en) begin
        if (tcnt == WP - 1) begin
          tcnt <= 0;
          pend <= 1'b1;
        end else begin
          tcnt <= tcnt + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (pend && arstn) begin
      nb++;
      if (sbq.size() != 0) begin
        me = sbq.pop_front();
        if (sel)
          chk($sformatf("word%0d {data,fd,un,busy}", nb), {1'b0, data2, fd2, un2, busy2},
              {1'b0, me.data, me.fd, me.un, me.busy});
        else
          chk($sformatf("word%0d {data,fd,un,busy}", nb), {1'b0, data1, fd1, un1, busy1},
              {1'b0, me.data, me.fd, me.un, me.busy});
      end
    end
  end

  task automatic do_reset();
    en_tog = 1'b0;
    en = 1'b0;
    s_valid = 1'b0;
    sbq.delete();
    @(negedge clk);
    arstn = 1'b0;
    repeat (3) @(negedge clk);
    arstn = 1'b1;
    nb = 0;
  endtask

  task automatic push(input logic [11:0] d, input logic l);
    int k = 0;
    @(negedge clk);
    s_valid = 1'b1; s_data = d; s_last = l;
    while (!(sel ? s_ready2 : s_ready1) && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) begin
      checks++; errors++;
      $display("FAIL push_timeout: word %h not accepted, required acceptance within 200 cycles", d);
    end
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic drain(input string nm, input int lim);
    int k = 0;
    while (sbq.size() != 0 && k < lim) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_drain_left"}, 16'(sbq.size()), 16'd0);
  endtask

  task automatic wait_nb(input int n);
    int k = 0;
    while (nb < n && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("wait_boundary_reached", 16'(nb >= n), 16'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vin_t t1_in[2];
    exp_t t1_exp[6];
    exp_t t2_exp[13];
    exp_t t3_exp[8];
    exp_t t6_exp[7];

    t1_in[0] = '{data: 12'h123, last: 1'b0};
    t1_in[1] = '{data: 12'h456, last: 1'b1};
    t1_exp = '{mk(12'hA5A,0,0,1), mk(12'hA5A,0,0,1), mk(12'h123,0,0,1),
               mk(12'h456,0,0,1), mk(12'h000,0,0,1), mk(12'h000,1,0,0)};
    t2_exp[0] = mk(12'hA5A,0,0,1);
    t2_exp[1] = mk(12'hA5A,0,0,1);
    for (int i = 0; i < 9; i++) t2_exp[i+2] = mk(12'h100 + 12'(i), 0, 0, 1);
    t2_exp[11] = mk(12'h000,0,0,1);
    t2_exp[12] = mk(12'h000,1,0,0);
    t3_exp = '{mk(12'hA5A,0,0,1), mk(12'hA5A,0,0,1), mk(12'h111,0,0,1),
               mk(12'h000,0,1,1), mk(12'h000,0,1,1), mk(12'h222,0,0,1),
               mk(12'h000,0,0,1), mk(12'h000,1,0,0)};
    t6_exp = '{mk(12'hA5A,0,0,1), mk(12'hA5A,0,0,1), mk(12'hAAA,0,0,1),
               mk(12'hA5A,1,0,1), mk(12'hA5A,0,0,1), mk(12'hCCC,0,0,1),
               mk(12'h000,1,0,0)};

    // Reset state
    do_reset();
    chk("reset_data_out", {4'h0, data1}, 16'h0000);
    chk("reset_busy", {15'h0, busy1}, 16'h0000);
    chk("reset_frame_done", {15'h0, fd1}, 16'h0000);
    chk("reset_underrun", {15'h0, un1}, 16'h0000);
    chk("reset_s_ready", {15'h0, s_ready1}, 16'h0001);

    // T1: basic frame
    for (int i = 0; i < 2; i++) push(t1_in[i].data, t1_in[i].last);
    for (int i = 0; i < 6; i++) sbq.push_back(t1_exp[i]);
    en = 1'b1;
    drain("t1", 200);

    // T2: FIFO fills while en is low, ninth write waits for the first pop
    do_reset();
    for (int i = 0; i < 8; i++) push(12'h100 + 12'(i), 1'b0);
    chk("t2_s_ready_full", {15'h0, s_ready1}, 16'h0000);
    for (int i = 0; i < 13; i++) sbq.push_back(t2_exp[i]);
    en = 1'b1;
    wait_nb(2);
    chk("t2_s_ready_still_full", {15'h0, s_ready1}, 16'h0000);
    push(12'h108, 1'b1);
    drain("t2", 300);

    // T3: underrun while waiting for the last word
    do_reset();
    push(12'h111, 1'b0);
    for (int i = 0; i < 8; i++) sbq.push_back(t3_exp[i]);
    en = 1'b1;
    wait_nb(5);
    push(12'h222, 1'b1);
    drain("t3", 200);

    // T4: 50% enable duty, same sequence as T1
    do_reset();
    for (int i = 0; i < 2; i++) push(t1_in[i].data, t1_in[i].last);
    for (int i = 0; i < 6; i++) sbq.push_back(t1_exp[i]);
    en_tog = 1'b1;
    drain("t4", 400);
    en_tog = 1'b0;

    // T5: reset during payload word B
    do_reset();
    for (int i = 0; i < 2; i++) push(t1_in[i].data, t1_in[i].last);
    for (int i = 0; i < 4; i++) sbq.push_back(t1_exp[i]);
    en = 1'b1;
    wait_nb(4);
    @(negedge clk);
    arstn = 1'b0;
    #1;
    chk("t5_async_data_out", {4'h0, data1}, 16'h0000);
    chk("t5_async_busy", {15'h0, busy1}, 16'h0000);
    chk("t5_async_s_ready", {15'h0, s_ready1}, 16'h0001);
    repeat (2) @(negedge clk);
    arstn = 1'b1;
    nb = 0;
    for (int i = 0; i < 3; i++) sbq.push_back(mk(12'h000,0,0,0));
    drain("t5", 200);

    // T6: back-to-back frames with no gap
    sel = 1'b1;
    do_reset();
    push(12'hAAA, 1'b1);
    push(12'hCCC, 1'b1);
    for (int i = 0; i < 7; i++) sbq.push_back(t6_exp[i]);
    en = 1'b1;
    drain("t6", 200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
